// File: rtl/ld_indirect_pkg.sv
// Shared definitions for the indirect accumulator-transfer sequencer.
// Latency: n/a (types, constants and small decode helpers only).
// Backpressure: n/a.
package ld_indirect_pkg;

  // Sequencer phases within one M-cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_XFER = 2'd2,
    ST_PAD  = 2'd3
  } state_e;

  // Pointer-pair select, one-hot
  localparam logic [3:0] P_BC  = 4'b0001;
  localparam logic [3:0] P_DE  = 4'b0010;
  localparam logic [3:0] P_HLI = 4'b0100;
  localparam logic [3:0] P_HLD = 4'b1000;

  // Bit positions inside the 6-bit 16-bit-register read/write vectors
  localparam int R16_BC = 1;
  localparam int R16_DE = 2;
  localparam int R16_HL = 3;
  localparam int W16_HL = 3;

  // Transfer direction, one-hot
  localparam logic [1:0] Q_STORE = 2'b01;
  localparam logic [1:0] Q_LOAD  = 2'b10;

  // Full set of registered control outputs
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       error;
    logic       ir_fetch;
    logic [5:0] read16;
    logic [5:0] write16;
    logic [1:0] inc16;
    logic       addr_out;
    logic [1:0] read_alu8;
    logic [1:0] write_alu8;
    logic       move_reg;
    logic       bus_in;
    logic       bus_out;
  } strobe_t;

  // A start is legal only with exactly one pair and exactly one direction
  function automatic logic start_ok(input logic [3:0] p, input logic [1:0] q);
    return $onehot(p) && ((q == Q_STORE) || (q == Q_LOAD));
  endfunction

  function automatic logic is_hl(input logic [3:0] p);
    return p[2] | p[3];
  endfunction

  // Read16 enable for the selected pair
  function automatic logic [5:0] r16_mask(input logic [3:0] p);
    logic [5:0] m;
    m = '0;
    if (p[0])      m[R16_BC] = 1'b1;
    else if (p[1]) m[R16_DE] = 1'b1;
    else           m[R16_HL] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ld_indirect_seq_if.sv
// Handshake and control-strobe bundle between the control unit and the sequencer.
// Latency: n/a (wires only).
// Backpressure: i_Mem_Ready low stalls the bus-access T-state.
interface ld_indirect_seq_if #(
  parameter int CNT_W = 5
);
  logic             i_Start;
  logic [3:0]       i_P;
  logic [1:0]       i_Q;
  logic [CNT_W-1:0] i_Bytes;
  logic             i_Mem_Ready;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Error;
  logic             o_IR_Fetch;
  logic [5:0]       o_Read16;
  logic [5:0]       o_Write16;
  logic [1:0]       o_Increment16;
  logic             o_Address_Out;
  logic [1:0]       o_ReadALU8;
  logic [1:0]       o_WriteALU8;
  logic             o_Move_Reg;
  logic             o_Bus_In;
  logic             o_Bus_Out;

  modport master (
    output i_Start, i_P, i_Q, i_Bytes, i_Mem_Ready,
    input  o_Busy, o_Done, o_Error, o_IR_Fetch, o_Read16, o_Write16, o_Increment16,
           o_Address_Out, o_ReadALU8, o_WriteALU8, o_Move_Reg, o_Bus_In, o_Bus_Out
  );

  modport slave (
    input  i_Start, i_P, i_Q, i_Bytes, i_Mem_Ready,
    output o_Busy, o_Done, o_Error, o_IR_Fetch, o_Read16, o_Write16, o_Increment16,
           o_Address_Out, o_ReadALU8, o_WriteALU8, o_Move_Reg, o_Bus_In, o_Bus_Out
  );
endinterface

// File: rtl/ld_indirect_seq_mcycle_timer.sv
// T-step counter modulo STEPS with stall, giving current and next last-step flags.
// Latency: step advances one per clock while running and not stalled.
// Backpressure: i_Stall freezes the step; !i_Run holds it at zero.
module mcycle_timer #(
  parameter int STEPS  = 4,
  parameter int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Run,
  input  logic i_Stall,
  output logic o_Last,
  output logic o_Last_Next
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic [STEP_W-1:0] step_q, step_d;

  // Next step: park at zero when idle, hold on stall, wrap after the last step
  always_comb begin
    step_d = step_q;
    if (!i_Run) begin
      step_d = '0;
    end else if (!i_Stall) begin
      step_d = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
    end
  end

  // Step register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) step_q <= '0;
    else         step_q <= step_d;
  end

  assign o_Last      = (step_q == LAST_STEP);
  assign o_Last_Next = (step_d == LAST_STEP);

endmodule

// File: rtl/ld_indirect_seq.sv
// Clocked microcode sequencer for LD (rr),A / LD A,(rr) with HL+/- block repeats.
// Latency: ADDR one cycle after start; Done at N*STEPS (+1 per wait), Busy drops one later.
// Backpressure: i_Mem_Ready low holds XFER and its strobes; starts while busy are ignored.
module ld_indirect_seq
  import ld_indirect_pkg::*;
#(
  parameter int STEPS     = 4,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  ld_indirect_seq_if.slave     bus
);

  state_e           state_q, state_d;
  logic [3:0]       p_q, p_d;
  logic [1:0]       q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobe_t          strobe_q, strobe_d;

  logic             start_err;
  logic [CNT_W-1:0] start_cnt;
  logic             run, stall, last, last_next;

  assign run   = (state_q != ST_IDLE);
  assign stall = (state_q == ST_XFER) && !bus.i_Mem_Ready;

  mcycle_timer #(.STEPS(STEPS)) u_timer (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Run       (run),
    .i_Stall     (stall),
    .o_Last      (last),
    .o_Last_Next (last_next)
  );

  // Byte count for a new start: BC/DE always one, HL+/- zero->1 and clamped to MAX_BYTES
  always_comb begin
    start_cnt = CNT_W'(1);
    if (is_hl(bus.i_P) && (bus.i_Bytes != '0)) begin
      start_cnt = (int'(bus.i_Bytes) > MAX_BYTES) ? CNT_W'(MAX_BYTES) : bus.i_Bytes;
    end
  end

  // Phase sequencing and latching of the launched operation
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    start_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          if (start_ok(bus.i_P, bus.i_Q)) begin
            state_d = ST_ADDR;
            p_d     = bus.i_P;
            q_d     = bus.i_Q;
            cnt_d   = start_cnt;
          end else begin
            start_err = 1'b1;
          end
        end
      end
      ST_ADDR: state_d = ST_XFER;
      ST_XFER: if (bus.i_Mem_Ready) state_d = ST_PAD;
      ST_PAD: begin
        if (last) begin
          if (cnt_q > CNT_W'(1)) begin
            state_d = ST_ADDR;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            p_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes for the coming cycle, decoded from next-state so they leave a flop
  always_comb begin
    strobe_d       = '0;
    strobe_d.error = start_err;
    if (state_d != ST_IDLE) begin
      strobe_d.busy     = 1'b1;
      strobe_d.ir_fetch = (cnt_d == CNT_W'(1));
    end
    case (state_d)
      ST_ADDR: begin
        strobe_d.addr_out = 1'b1;
        strobe_d.read16   = r16_mask(p_d);
        if (is_hl(p_d)) begin
          strobe_d.write16[W16_HL] = 1'b1;
          strobe_d.inc16           = {p_d[3], 1'b1};
        end
      end
      ST_XFER: begin
        if (q_d == Q_STORE) begin
          strobe_d.read_alu8[0] = 1'b1;
          strobe_d.move_reg     = 1'b1;
          strobe_d.bus_out      = 1'b1;
        end else begin
          strobe_d.write_alu8[0] = 1'b1;
          strobe_d.bus_in        = 1'b1;
        end
      end
      ST_PAD:  strobe_d.done = last_next && (cnt_d == CNT_W'(1));
      default: ;
    endcase
  end

  // State, operand latches and output strobes
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.o_Busy        = strobe_q.busy;
  assign bus.o_Done        = strobe_q.done;
  assign bus.o_Error       = strobe_q.error;
  assign bus.o_IR_Fetch    = strobe_q.ir_fetch;
  assign bus.o_Read16      = strobe_q.read16;
  assign bus.o_Write16     = strobe_q.write16;
  assign bus.o_Increment16 = strobe_q.inc16;
  assign bus.o_Address_Out = strobe_q.addr_out;
  assign bus.o_ReadALU8    = strobe_q.read_alu8;
  assign bus.o_WriteALU8   = strobe_q.write_alu8;
  assign bus.o_Move_Reg    = strobe_q.move_reg;
  assign bus.o_Bus_In      = strobe_q.bus_in;
  assign bus.o_Bus_Out     = strobe_q.bus_out;

endmodule

// File: tb/tb_ld_indirect_seq.sv
// Randomized bench for ld_indirect_seq with a cycle-timeline reference model.
// Expected non-idle output cycles are queued at issue time; a monitor checks them.
// Memory waits are scheduled by the model into the XFER windows it predicts.
module tb_ld_indirect_seq;

  localparam int STEPS     = 4;
  localparam int MAX_BYTES = 16;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  typedef struct {
    int          cyc;
    logic [25:0] v;
  } exp_t;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   rdy_plan[int];
  logic [25:0] obs;

  ld_indirect_seq_if #(.CNT_W(CNT_W)) bus ();

  ld_indirect_seq #(.STEPS(STEPS), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  assign obs = {bus.o_Busy, bus.o_Done, bus.o_Error, bus.o_IR_Fetch, bus.o_Read16,
                bus.o_Write16, bus.o_Increment16, bus.o_Address_Out, bus.o_ReadALU8,
                bus.o_WriteALU8, bus.o_Move_Reg, bus.o_Bus_In, bus.o_Bus_Out};

  function automatic logic [25:0] mk(input bit busy, input bit done, input bit err,
                                     input bit ir, input logic [5:0] rd, input logic [5:0] wr,
                                     input logic [1:0] inc, input bit addr,
                                     input logic [1:0] ra, input logic [1:0] wa,
                                     input bit mv, input bit bin, input bit bout);
    return {busy, done, err, ir, rd, wr, inc, addr, ra, wa, mv, bin, bout};
  endfunction

  // Monitor: any cycle with a non-zero output must match the next queued expectation
  always begin
    exp_t e;
    @(posedge i_Clk);
    #1;
    if (obs != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d got=%h (nothing expected)", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v != obs) begin
          failures++;
          $display("FAIL out_vec cyc=%0d got=%h want cyc=%0d vec=%h", cyc, obs, e.cyc, e.v);
        end
      end
    end
  end

  // Issue one start at the current negedge, queue the model timeline, drive until idle.
  // wfix>=0 gives every byte that many waits, -1 picks them randomly.
  // abort>0 keeps only expectations up to start+abort and returns at that cycle's negedge.
  task automatic do_txn(input logic [3:0] p, input logic [1:0] q, input int bytes,
                        input int wfix, input int abort);
    int s, n, t, w, endc;
    bit ok, hl, lb;
    logic [5:0] rd, wr;
    logic [1:0] inc;
    ok = ($countones(p) == 1) && (q == 2'b01 || q == 2'b10);
    hl = p[2] | p[3];
    n  = !hl ? 1 : (bytes == 0 ? 1 : (bytes > MAX_BYTES ? MAX_BYTES : bytes));
    s  = cyc;
    bus.i_Start     = 1'b1;
    bus.i_P         = p;
    bus.i_Q         = q;
    bus.i_Bytes     = CNT_W'(bytes);
    bus.i_Mem_Ready = 1'($urandom_range(0, 1));
    rdy_plan.delete();
    if (!ok) begin
      exp_q.push_back('{s + 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      endc = s;
    end else begin
      rd  = p[0] ? 6'b000010 : (p[1] ? 6'b000100 : 6'b001000);
      wr  = hl ? 6'b001000 : 6'b000000;
      inc = hl ? {p[3], 1'b1} : 2'b00;
      t   = s + 1;
      for (int k = 0; k < n; k++) begin
        lb = (k == n - 1);
        w  = (wfix >= 0) ? wfix : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        exp_q.push_back('{t, mk(1, 0, 0, lb, rd, wr, inc, 1, 0, 0, 0, 0, 0)});
        for (int x = 0; x <= w; x++) begin
          if (q == 2'b01) exp_q.push_back('{t + 1 + x, mk(1, 0, 0, lb, 0, 0, 0, 0, 2'b01, 0, 1, 0, 1)});
          else            exp_q.push_back('{t + 1 + x, mk(1, 0, 0, lb, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0)});
          rdy_plan[t + 1 + x] = (x == w);
        end
        for (int y = 2; y < STEPS; y++)
          exp_q.push_back('{t + w + y, mk(1, lb && (y == STEPS - 1), 0, lb, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        t += STEPS + w;
      end
      endc = t - 1;
      if (abort > 0) begin
        while (exp_q.size() > 0 && exp_q[$].cyc > s + abort) void'(exp_q.pop_back());
        endc = s + abort - 1;
      end
    end
    @(negedge i_Clk);
    while (cyc <= endc) begin
      bus.i_Mem_Ready = rdy_plan.exists(cyc) ? rdy_plan[cyc] : 1'($urandom_range(0, 1));
      bus.i_Start     = ($urandom_range(0, 3) == 0);
      bus.i_P         = 4'($urandom_range(0, 15));
      bus.i_Q         = 2'($urandom_range(0, 3));
      bus.i_Bytes     = CNT_W'($urandom_range(0, 31));
      @(negedge i_Clk);
    end
    bus.i_Start = 1'b0;
  endtask

  task automatic idle_gap();
    bus.i_Start = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge i_Clk);
  endtask

  initial begin
    logic [3:0] rp;
    logic [1:0] rq;
    bus.i_Start = 1'b0;
    bus.i_P = '0;
    bus.i_Q = '0;
    bus.i_Bytes = '0;
    bus.i_Mem_Ready = 1'b1;
    repeat (2) @(negedge i_Clk);
    checks++;
    if (obs != '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    i_Reset = 1'b0;
    @(negedge i_Clk);

    // Directed cases
    do_txn(4'b0001, 2'b01, 0, 0, 0);            idle_gap();  // store via BC
    do_txn(4'b0100, 2'b10, 3, 0, 0);            idle_gap();  // load via HL+, 3 bytes
    do_txn(4'b1000, 2'b10, 1, 2, 0);            idle_gap();  // HL-, two waits
    do_txn(4'b0001, 2'b11, 1, 0, 0);                         // bad direction
    do_txn(4'b0011, 2'b01, 1, 0, 0);            idle_gap();  // bad pair
    do_txn(4'b0100, 2'b01, 0, 0, 0);                         // Bytes=0 -> 1
    do_txn(4'b0010, 2'b10, 5, 0, 0);            idle_gap();  // DE ignores Bytes
    do_txn(4'b1000, 2'b01, MAX_BYTES + 3, -1, 0); idle_gap(); // clamp

    // Random cases
    for (int i = 0; i < 40; i++) begin
      rp = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rq = ($urandom_range(0, 4) != 0) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
      do_txn(rp, rq, int'($urandom_range(0, MAX_BYTES + 3)), -1, 0);
      idle_gap();
    end

    // Asynchronous reset in cycle 6 of a 3-byte run
    do_txn(4'b0100, 2'b10, 3, 0, 6);
    i_Reset = 1'b1;
    #1;
    checks++;
    if (obs != '0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", obs);
    end
    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b0;
    @(negedge i_Clk);
    do_txn(4'b0100, 2'b10, 3, -1, 0);
    do_txn(4'b0010, 2'b01, 0, -1, 0);

    // Drain
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge i_Clk);
    repeat (3) @(negedge i_Clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0 (first expected cyc=%0d)", exp_q.size(), exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ld_indirect_seq.md
# ld_indirect_seq

Sequential microcode engine for accumulator-to/from-memory transfers through a register-pair pointer: LD (BC),A, LD (DE),A, LD (HL+),A, LD (HL-),A and the load directions. It generalises the per-instruction combinational microcode into a clocked sequencer with its own T-state and byte counters. It adds memory wait states and HL block repeats. It sits in the ControlUnit beside the other microcode blocks and drives the same register-file, ALU and bus control lines.

## Interface
Parameters:
- STEPS, 4, T-states per M-cycle (≥3)
- MAX_BYTES, 16, maximum repeat count for HL± transfers
- CNT_W, $clog2(MAX_BYTES+1), width of i_Bytes

Ports:
- i_Clk  in  1  system clock; all state on rising edge
- i_Reset  in  1  reset; **one clock; reset is asynchronous and active-high**
- i_Start  in  1  launch pulse; accepted only when o_Busy=0
- i_P  in  4  pointer select, one-hot: [0]=BC, [1]=DE, [2]=HL+, [3]=HL-
- i_Q  in  2  direction, one-hot: [0]=store A→mem, [1]=load mem→A
- i_Bytes  in  CNT_W  repeat count (HL± only)
- i_Mem_Ready  in  1  memory ready; low stalls the bus-access T-state
- o_Busy  out  1  sequence in progress
- o_Done  out  1  one-cycle pulse on the final T-state
- o_Error  out  1  one-cycle pulse on a rejected start
- o_IR_Fetch  out  1  overlapped opcode fetch request
- o_Read16  out  6  pointer read enable: bit1=BC, bit2=DE, bit3=HL
- o_Write16  out  6  pointer writeback: bit3=HL
- o_Increment16  out  2  [0]=inc/dec enable, [1]=decrement
- o_Address_Out  out  1  drive address bus
- o_ReadALU8, o_WriteALU8  out  2  A-register read/write ([0]=A)
- o_Move_Reg, o_Bus_In, o_Bus_Out  out  1  datapath steering

## Operation
- States: IDLE, ADDR, XFER, PAD.
- IDLE with i_Start=1:
  - If i_Q ∉ {01,10}, or i_P is not one-hot: pulse o_Error and stay IDLE.
  - Otherwise latch P, Q and count, then go to ADDR.
- Count rules:
  - BC/DE forces count=1.
  - HL±: i_Bytes=0 is treated as 1; values above MAX_BYTES are clamped to MAX_BYTES.
- ADDR (T-step 0) asserts:
  - o_Address_Out=1
  - o_Read16 bit for the latched pair
  - For HL± only: o_Write16[3]=1, o_Increment16={P[3],1}
- XFER (T-step 1), bus access:
  - Store: o_ReadALU8[0]=1, o_Move_Reg=1, o_Bus_Out=1.
  - Load: o_WriteALU8[0]=1, o_Bus_In=1.
  - While i_Mem_Ready=0: stay in XFER, freeze the T counter, hold the strobes.
- PAD (T-steps 2..STEPS-1): no strobes. At T-step STEPS-1:
  - If bytes remain: decrement the remaining count and go to ADDR.
  - Otherwise: pulse o_Done and go to IDLE.
- o_IR_Fetch=1 during every T-state of the final byte's M-cycle.
- i_Start while busy is ignored, with no error.

## Timing
- Reset: state IDLE, counters 0, every output 0. Reset asserted mid-sequence aborts immediately, with no further strobes; the pointer keeps whatever updates already happened.
- Start is sampled at cycle 0. ADDR is at cycle 1. With no waits, o_Done is at cycle N·STEPS, and o_Busy falls at cycle N·STEPS+1.
- Each cycle with i_Mem_Ready=0 in XFER adds one cycle of latency.
- A new i_Start is accepted in the first cycle with o_Busy=0.
- Strobes are registered, so outputs change only on clock edges.

## Structure
- Shared package ld_indirect_pkg:
  - state encoding
  - pair one-hot constants (P_BC, P_DE, P_HLI, P_HLD)
  - Read16/Write16 bit indices
  - direction constants
- Sub-module mcycle_timer:
  - T-step counter modulo STEPS with a stall input and a last-step flag
  - reusable by the other sequenced microcode blocks

## Test plan
- Store via BC, STEPS=4, ready=1 → Address_Out and Read16=000010 at cycle 1; Bus_Out/ReadALU8=01 at cycle 2; Done at cycle 4; no Increment16.
- Load via HL+, Bytes=3 → three ADDR phases at cycles 1, 5, 9, each with Write16=001000 and Increment16=01; WriteALU8=01 at cycles 2, 6, 10; IR_Fetch during cycles 9–12; Done at cycle 12.
- HL-, Bytes=1, i_Mem_Ready low for 2 cycles in XFER → Increment16=11; strobes held for 3 cycles; Done at cycle 6.
- i_Q=11 or i_P=0011 → o_Error pulse; o_Busy stays 0; all strobes 0.
- Bytes=0 with HL+ and Bytes=5 with DE → one byte each. Bytes=MAX_BYTES+3 → MAX_BYTES bytes.
- Reset asserted at cycle 6 of a 3-byte run → all outputs 0 asynchronously; next start runs normally.
